pwm_servo_p: RTL

Downstream stage of the servo proportional path: it consumes the registered signed P-term product and its load strobe, then scales, offsets and saturates the value into a servo pulse width. The new width is committed only at a PWM period boundary, so the pulse output never glitches. It sits between the P-term register and the servo pin.

---
 rtl/servo_pkg.sv | 19 +
 rtl/pwm_servo_p_if.sv | 27 ++
 rtl/pwm_contador.sv | 51 +++++
 rtl/pwm_servo_p.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared types and default constants for the servo proportional-path PWM stage.
package servo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CAPT   = 3'd1,
    ST_ESC    = 3'd2,
    ST_SUMA   = 3'd3,
    ST_SATU   = 3'd4,
    ST_ESPERA = 3'd5
  } servo_st_e;

  localparam int SERVO_DUTY_OFF = 750;
  localparam int SERVO_DUTY_MIN = 500;
  localparam int SERVO_DUTY_MAX = 1000;
  localparam int SERVO_PWM_PER  = 10000;
  localparam int SERVO_PRESC    = 100;

endpackage

// File: rtl/pwm_servo_p_if.sv
// Bus between the P-term register and the servo PWM stage.
// The Sat line exists only when PWM_SAT_FLAG_EN is defined.
interface pwm_servo_p_if #(
  parameter int CANT_BITS = 13,
  parameter int PWM_BITS  = 14
);

  logic signed [2*CANT_BITS-1:0] R_Mul_P;
  logic                          Ld_P;
  logic                          Pwm_Out;
  logic [PWM_BITS-1:0]           Duty;
  logic                          Busy;
`ifdef PWM_SAT_FLAG_EN
  logic                          Sat;

  modport master (output R_Mul_P, output Ld_P,
                  input Pwm_Out, input Duty, input Busy, input Sat);
  modport slave  (input R_Mul_P, input Ld_P,
                  output Pwm_Out, output Duty, output Busy, output Sat);
`else
  modport master (output R_Mul_P, output Ld_P,
                  input Pwm_Out, input Duty, input Busy);
  modport slave  (input R_Mul_P, input Ld_P,
                  output Pwm_Out, output Duty, output Busy);
`endif

endinterface

// File: rtl/pwm_contador.sv
// Free-running PWM timebase: prescaler producing tick, and the period counter.
module pwm_contador #(
  parameter int PRESC    = 100,
  parameter int PWM_PER  = 10000,
  parameter int PWM_BITS = 14
) (
  input  logic                Clk_G,
  input  logic                Rst_G,
  output logic                tick,
  output logic [PWM_BITS-1:0] cnt,
  output logic                fin_per
);

  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0]       PRESC_LAST = PW'(PRESC - 1);
  localparam logic [PWM_BITS-1:0] CNT_LAST   = PWM_BITS'(PWM_PER - 1);

  logic [PW-1:0]       presc_r;
  logic [PWM_BITS-1:0] cnt_r;

  // Prescaler: wraps every PRESC clocks
  always_ff @(posedge Clk_G or posedge Rst_G) begin
    if (Rst_G) begin
      presc_r <= '0;
    end else if (presc_r == PRESC_LAST) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  // Period counter: advances on tick, wraps after PWM_PER ticks
  always_ff @(posedge Clk_G or posedge Rst_G) begin
    if (Rst_G) begin
      cnt_r <= '0;
    end else if (tick) begin
      if (cnt_r == CNT_LAST) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + PWM_BITS'(1);
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tick    = (presc_r == PRESC_LAST);
  assign cnt     = cnt_r;
  assign fin_per = tick && (cnt_r == CNT_LAST);

endmodule

// File: rtl/pwm_servo_p.sv
// Scales, offsets and clamps the P-term product into a servo pulse width,
// committed only at a PWM period boundary. PWM_SAT_FLAG_EN adds the Sat flag.
module pwm_servo_p
  import servo_pkg::*;
#(
  parameter int CANT_BITS = 13,
  parameter int FRAC      = 5,
  parameter int PWM_BITS  = 14,
  parameter int PRESC     = SERVO_PRESC,
  parameter int PWM_PER   = SERVO_PWM_PER,
  parameter int DUTY_OFF  = SERVO_DUTY_OFF,
  parameter int DUTY_MIN  = SERVO_DUTY_MIN,
  parameter int DUTY_MAX  = SERVO_DUTY_MAX
) (
  input  logic          Clk_G,
  input  logic          Rst_G,
  pwm_servo_p_if.slave  bus
);

  localparam int PW2 = 2 * CANT_BITS;
  localparam int SW  = PW2 + 1;

  localparam logic signed [SW-1:0] OFF_S = SW'(DUTY_OFF);
  localparam logic signed [SW-1:0] MIN_S = SW'(DUTY_MIN);
  localparam logic signed [SW-1:0] MAX_S = SW'(DUTY_MAX);
  localparam logic [PWM_BITS-1:0]  OFF_W = PWM_BITS'(DUTY_OFF);
  localparam logic [PWM_BITS-1:0]  MIN_W = PWM_BITS'(DUTY_MIN);
  localparam logic [PWM_BITS-1:0]  MAX_W = PWM_BITS'(DUTY_MAX);

  servo_st_e state_r, state_next_s;

  logic                  tick_s;
  logic [PWM_BITS-1:0]   cnt_s;
  logic                  fin_per_s;

  logic signed [PW2-1:0] capt_r;
  logic signed [PW2-1:0] esc_r;
  logic signed [SW-1:0]  suma_r;
  logic [PWM_BITS-1:0]   pend_r;
  logic [PWM_BITS-1:0]   duty_r;
  logic [PWM_BITS-1:0]   clamp_s;
  logic                  capt_en_s;
  logic                  commit_s;
  logic                  pwm_r;
  logic                  busy_r;
`ifdef PWM_SAT_FLAG_EN
  logic                  clamp_sat_s;
  logic                  pend_sat_r;
  logic                  sat_r;
`endif

  pwm_contador #(
    .PRESC    (PRESC),
    .PWM_PER  (PWM_PER),
    .PWM_BITS (PWM_BITS)
  ) u_contador (
    .Clk_G   (Clk_G),
    .Rst_G   (Rst_G),
    .tick    (tick_s),
    .cnt     (cnt_s),
    .fin_per (fin_per_s)
  );

  // FSM state register
  always_ff @(posedge Clk_G or posedge Rst_G) begin
    if (Rst_G) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state; a strobe in ESPERA restarts the pipeline even on a commit edge
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.Ld_P) begin
          state_next_s = ST_CAPT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CAPT: state_next_s = ST_ESC;
      ST_ESC:  state_next_s = ST_SUMA;
      ST_SUMA: state_next_s = ST_SATU;
      ST_SATU: state_next_s = ST_ESPERA;
      ST_ESPERA: begin
        if (bus.Ld_P) begin
          state_next_s = ST_CAPT;
        end else if (commit_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_ESPERA;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  assign capt_en_s = bus.Ld_P && ((state_r == ST_IDLE) || (state_r == ST_ESPERA));
  assign commit_s  = (state_r == ST_ESPERA) && tick_s && fin_per_s;

  // Saturation of the offset sum into the legal pulse range
  always_comb begin
    clamp_s = suma_r[PWM_BITS-1:0];
`ifdef PWM_SAT_FLAG_EN
    clamp_sat_s = 1'b0;
`endif
    if (suma_r < MIN_S) begin
      clamp_s = MIN_W;
`ifdef PWM_SAT_FLAG_EN
      clamp_sat_s = 1'b1;
`endif
    end else if (suma_r > MAX_S) begin
      clamp_s = MAX_W;
`ifdef PWM_SAT_FLAG_EN
      clamp_sat_s = 1'b1;
`endif
    end else begin
      clamp_s = suma_r[PWM_BITS-1:0];
    end
  end

  // Datapath pipeline: capture, scale, offset, clamp, commit
  always_ff @(posedge Clk_G or posedge Rst_G) begin
    if (Rst_G) begin
      capt_r <= '0;
      esc_r  <= '0;
      suma_r <= '0;
      pend_r <= OFF_W;
      duty_r <= OFF_W;
    end else begin
      if (capt_en_s) begin
        capt_r <= bus.R_Mul_P;
      end else begin
        capt_r <= capt_r;
      end
      case (state_r)
        ST_CAPT: esc_r  <= capt_r >>> FRAC;
        ST_ESC:  suma_r <= $signed({esc_r[PW2-1], esc_r}) + OFF_S;
        ST_SUMA: pend_r <= clamp_s;
        default: begin
          esc_r  <= esc_r;
          suma_r <= suma_r;
          pend_r <= pend_r;
        end
      endcase
      if (commit_s) begin
        duty_r <= pend_r;
      end else begin
        duty_r <= duty_r;
      end
    end
  end

`ifdef PWM_SAT_FLAG_EN
  // Saturation flag travels with pend and commits with Duty
  always_ff @(posedge Clk_G or posedge Rst_G) begin
    if (Rst_G) begin
      pend_sat_r <= 1'b0;
      sat_r      <= 1'b0;
    end else begin
      if (state_r == ST_SUMA) begin
        pend_sat_r <= clamp_sat_s;
      end else begin
        pend_sat_r <= pend_sat_r;
      end
      if (commit_s) begin
        sat_r <= pend_sat_r;
      end else begin
        sat_r <= sat_r;
      end
    end
  end

  assign bus.Sat = sat_r;
`endif

  // Registered pulse and busy outputs
  always_ff @(posedge Clk_G or posedge Rst_G) begin
    if (Rst_G) begin
      pwm_r  <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      pwm_r  <= (cnt_s < duty_r);
      busy_r <= (state_next_s != ST_IDLE);
    end
  end

  assign bus.Pwm_Out = pwm_r;
  assign bus.Duty    = duty_r;
  assign bus.Busy    = busy_r;

endmodule
